mc_main_ctrl: RTL and testbench

//  Multi-cycle MIPS main control FSM: produces ALU_OP and all datapath enables/selects each cycle.
//  ALU_OP is consumed by the ALU control decoder: 00 = add, 01 = sub, 10 = decode by funct.

---
 rtl/mc_ctrl_pkg.sv | 71 +++++++
 rtl/mc_ctrl_out_dec.sv | 81 ++++++++
 rtl/mc_main_ctrl.sv | 111 +++++++++++
 tb/tb_mc_main_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : Shared opcodes, select codes, state encoding and control bus type
//            for the multi-cycle MIPS main controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC     = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_ADDI_EX  = 4'd11,
        ST_ADDI_WB  = 4'd12
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_out_dec.sv
// ============================================================================
// Module   : mc_ctrl_out_dec
// Brief    : Combinational decode of controller state and MEM_READY into the
//            datapath control bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_out_dec
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   op_legal_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // PC+4 and IR load only commit once the fetch data is valid
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.illegal   = ~op_legal_i;
            end
            ST_MEM_ADDR, ST_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_RT;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            ST_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_main_ctrl.sv
// ============================================================================
// Module   : mc_main_ctrl
// Brief    : Multi-cycle MIPS main control FSM with retired-instruction count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       OPCODE,
    input  logic             MEM_READY,
    output logic             PC_WRITE,
    output logic             PC_WRITE_COND,
    output logic             I_OR_D,
    output logic             MEM_READ,
    output logic             MEM_WRITE,
    output logic             IR_WRITE,
    output logic             MEM_TO_REG,
    output logic             REG_DST,
    output logic             REG_WRITE,
    output logic             ALU_SRC_A,
    output logic [1:0]       ALU_SRC_B,
    output logic [1:0]       ALU_OP,
    output logic [1:0]       PC_SOURCE,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] INSTR_CNT
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire_w;
    logic             op_legal_w;
    ctrl_t            ctrl_w;

    assign op_legal_w = op_is_legal(OPCODE);

    always_comb begin
        state_d  = state_q;
        retire_w = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (MEM_READY) state_d = ST_DECODE;
            ST_DECODE: begin
                case (OPCODE)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: state_d = (OPCODE == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (MEM_READY) state_d = ST_MEM_WB;
            ST_MEM_WR: begin
                if (MEM_READY) begin
                    state_d  = ST_FETCH;
                    retire_w = 1'b1;
                end
            end
            ST_EXEC:    state_d = ST_R_WB;
            ST_ADDI_EX: state_d = ST_ADDI_WB;
            ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB: begin
                state_d  = ST_FETCH;
                retire_w = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire_w) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    mc_ctrl_out_dec u_out_dec (
        .state_i     (state_q),
        .mem_ready_i (MEM_READY),
        .op_legal_i  (op_legal_w),
        .ctrl_o      (ctrl_w)
    );

    assign PC_WRITE      = ctrl_w.pc_write;
    assign PC_WRITE_COND = ctrl_w.pc_write_cond;
    assign I_OR_D        = ctrl_w.i_or_d;
    assign MEM_READ      = ctrl_w.mem_read;
    assign MEM_WRITE     = ctrl_w.mem_write;
    assign IR_WRITE      = ctrl_w.ir_write;
    assign MEM_TO_REG    = ctrl_w.mem_to_reg;
    assign REG_DST       = ctrl_w.reg_dst;
    assign REG_WRITE     = ctrl_w.reg_write;
    assign ALU_SRC_A     = ctrl_w.alu_src_a;
    assign ALU_SRC_B     = ctrl_w.alu_src_b;
    assign ALU_OP        = ctrl_w.alu_op;
    assign PC_SOURCE     = ctrl_w.pc_source;
    assign ILLEGAL       = ctrl_w.illegal;
    assign INSTR_CNT     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_main_ctrl.sv
// ============================================================================
// Module   : tb_mc_main_ctrl
// Brief    : Directed self-checking bench for mc_main_ctrl (32-bit and 4-bit
//            counter instances driven in lockstep).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_main_ctrl;

    logic        clk;
    logic        rst_n;
    logic [5:0]  OPCODE;
    logic        MEM_READY;

    logic        PC_WRITE, PC_WRITE_COND, I_OR_D, MEM_READ, MEM_WRITE, IR_WRITE;
    logic        MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A, ILLEGAL;
    logic [1:0]  ALU_SRC_B, ALU_OP, PC_SOURCE;
    logic [31:0] INSTR_CNT;

    logic        b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw, b_sa, b_ill;
    logic [1:0]  b_sb, b_op, b_ps;
    logic [3:0]  cnt4;

    int n_checks;
    int n_fail;

    mc_main_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .OPCODE(OPCODE), .MEM_READY(MEM_READY),
        .PC_WRITE(PC_WRITE), .PC_WRITE_COND(PC_WRITE_COND), .I_OR_D(I_OR_D),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .IR_WRITE(IR_WRITE),
        .MEM_TO_REG(MEM_TO_REG), .REG_DST(REG_DST), .REG_WRITE(REG_WRITE),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP),
        .PC_SOURCE(PC_SOURCE), .ILLEGAL(ILLEGAL), .INSTR_CNT(INSTR_CNT)
    );

    mc_main_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .OPCODE(OPCODE), .MEM_READY(MEM_READY),
        .PC_WRITE(b_pcw), .PC_WRITE_COND(b_pcwc), .I_OR_D(b_iord),
        .MEM_READ(b_mr), .MEM_WRITE(b_mw), .IR_WRITE(b_irw),
        .MEM_TO_REG(b_m2r), .REG_DST(b_rd), .REG_WRITE(b_rw),
        .ALU_SRC_A(b_sa), .ALU_SRC_B(b_sb), .ALU_OP(b_op),
        .PC_SOURCE(b_ps), .ILLEGAL(b_ill), .INSTR_CNT(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCW,PCWC,IORD,MR,MW,IRW,M2R,RDST,RW,SA,SB[2],OP[2],PS[2],ILL}
    logic [16:0] ctl, ctl4;
    assign ctl  = {PC_WRITE, PC_WRITE_COND, I_OR_D, MEM_READ, MEM_WRITE, IR_WRITE,
                   MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A, ALU_SRC_B, ALU_OP,
                   PC_SOURCE, ILLEGAL};
    assign ctl4 = {b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw,
                   b_sa, b_sb, b_op, b_ps, b_ill};

    localparam logic [16:0] E_IDLE    = 17'b0;
    localparam logic [16:0] E_FETCH   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_FETCH_S = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_DEC_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
    localparam logic [16:0] E_MADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_MEM_RD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_MEM_WB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_MEM_WR  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_EXEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [16:0] E_R_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_BRANCH  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [16:0] E_JUMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
    localparam logic [16:0] E_ADDI_EX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] E_ADDI_WB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};

    localparam logic [5:0] OPC_R = 6'b000000, OPC_LW = 6'b100011, OPC_SW = 6'b101011;
    localparam logic [5:0] OPC_BEQ = 6'b000100, OPC_J = 6'b000010, OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_BAD = 6'b111111;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, check the decoded bus for the current state, advance one clock.
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [16:0] exp);
        OPCODE    = op;
        MEM_READY = rdy;
        #1;
        check(tag, {47'b0, ctl}, {47'b0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        OPCODE    = OPC_R;
        MEM_READY = 1'b1;
        #2;
        check("reset_ctl", {47'b0, ctl}, 64'd0);
        check("reset_cnt", {32'b0, INSTR_CNT}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc("idle", OPC_R, 1'b1, E_IDLE);

        // R-type: 4 cycles
        cyc("r_fetch",  OPC_R, 1'b1, E_FETCH);
        cyc("r_decode", OPC_R, 1'b1, E_DECODE);
        cyc("r_exec",   OPC_R, 1'b1, E_EXEC);
        cyc("r_wb",     OPC_R, 1'b1, E_R_WB);
        check("cnt_after_r", {32'b0, INSTR_CNT}, 64'd1);

        // lw with one fetch stall and three MEM_RD stalls
        cyc("lw_fetch_stall", OPC_LW, 1'b0, E_FETCH_S);
        cyc("lw_fetch",       OPC_LW, 1'b1, E_FETCH);
        cyc("lw_decode",      OPC_LW, 1'b1, E_DECODE);
        cyc("lw_addr",        OPC_LW, 1'b1, E_MADDR);
        for (int i = 0; i < 3; i++) cyc("lw_rd_stall", OPC_LW, 1'b0, E_MEM_RD);
        check("cnt_in_lw_stall", {32'b0, INSTR_CNT}, 64'd1);
        cyc("lw_rd",          OPC_LW, 1'b1, E_MEM_RD);
        cyc("lw_wb",          OPC_LW, 1'b1, E_MEM_WB);
        check("cnt_after_lw", {32'b0, INSTR_CNT}, 64'd2);

        cyc("beq_fetch",  OPC_BEQ, 1'b1, E_FETCH);
        cyc("beq_decode", OPC_BEQ, 1'b1, E_DECODE);
        cyc("beq_branch", OPC_BEQ, 1'b1, E_BRANCH);
        check("cnt_after_beq", {32'b0, INSTR_CNT}, 64'd3);

        cyc("j_fetch",  OPC_J, 1'b1, E_FETCH);
        cyc("j_decode", OPC_J, 1'b1, E_DECODE);
        cyc("j_jump",   OPC_J, 1'b1, E_JUMP);
        check("cnt_after_j", {32'b0, INSTR_CNT}, 64'd4);

        cyc("sw_fetch",  OPC_SW, 1'b1, E_FETCH);
        cyc("sw_decode", OPC_SW, 1'b1, E_DECODE);
        cyc("sw_addr",   OPC_SW, 1'b1, E_MADDR);
        cyc("sw_wr",     OPC_SW, 1'b1, E_MEM_WR);
        check("cnt_after_sw", {32'b0, INSTR_CNT}, 64'd5);

        cyc("addi_fetch",  OPC_ADDI, 1'b1, E_FETCH);
        cyc("addi_decode", OPC_ADDI, 1'b1, E_DECODE);
        cyc("addi_ex",     OPC_ADDI, 1'b1, E_ADDI_EX);
        cyc("addi_wb",     OPC_ADDI, 1'b1, E_ADDI_WB);
        check("cnt_after_addi", {32'b0, INSTR_CNT}, 64'd6);

        // Illegal opcode: one-cycle pulse in DECODE, straight back to FETCH, no retire
        cyc("ill_fetch",  OPC_BAD, 1'b1, E_FETCH);
        cyc("ill_decode", OPC_BAD, 1'b1, E_DEC_ILL);
        check("cnt_after_ill", {32'b0, INSTR_CNT}, 64'd6);
        check("cnt4_before_wrap", {60'b0, cnt4}, 64'd6);

        // Ten more jumps: 4-bit counter goes 6 -> 16 = wraps to 0
        for (int k = 0; k < 10; k++) begin
            cyc("wrap_fetch",  OPC_J, 1'b1, E_FETCH);
            cyc("wrap_decode", OPC_J, 1'b1, E_DECODE);
            cyc("wrap_jump",   OPC_J, 1'b1, E_JUMP);
        end
        check("cnt_after_16", {32'b0, INSTR_CNT}, 64'd16);
        check("cnt4_wrapped", {60'b0, cnt4}, 64'd0);
        check("ctl4_fetch", {47'b0, ctl4}, {47'b0, E_FETCH});

        // Asynchronous reset while sw is stalled in MEM_WR
        cyc("rst_sw_fetch",  OPC_SW, 1'b1, E_FETCH);
        cyc("rst_sw_decode", OPC_SW, 1'b1, E_DECODE);
        cyc("rst_sw_addr",   OPC_SW, 1'b1, E_MADDR);
        OPCODE    = OPC_SW;
        MEM_READY = 1'b0;
        #1;
        check("sw_wr_stall", {47'b0, ctl}, {47'b0, E_MEM_WR});
        #2;
        rst_n = 1'b0;
        #1;
        check("midstall_rst_ctl",  {47'b0, ctl}, 64'd0);
        check("midstall_rst_cnt",  {32'b0, INSTR_CNT}, 64'd0);
        check("midstall_rst_cnt4", {60'b0, cnt4}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("post_rst_idle",  OPC_R, 1'b1, E_IDLE);
        cyc("post_rst_fetch", OPC_R, 1'b1, E_FETCH);
        check("post_rst_cnt", {32'b0, INSTR_CNT}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
